// File: rtl/slot_game_ctrl.sv
// Three-reel slot machine controller: bet selection, spin sequencing with
// staggered reel stops, payout evaluation and win display timing.
module slot_game_ctrl #(
  parameter int         MONEY_INIT  = 100,
  parameter int         BET_MAX     = 9,
  parameter int         SPIN_FRAMES = 60,
  parameter int         STAGGER     = 20,
  parameter int         WIN_FRAMES  = 90,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_spin,
  output logic [9:0] money,
  output logic [3:0] bet,
  output logic [1:0] reel1,
  output logic [1:0] reel2,
  output logic [1:0] reel3,
  output logic       stop,
  output logic       win,
  output logic       busy
);

  localparam int         CNT_W      = 16;
  localparam int         REEL3_STOP = SPIN_FRAMES + 2 * STAGGER;
  localparam logic [9:0] MONEY_MAX  = 10'd999;

  typedef enum logic [1:0] {IDLE = 2'd0, SPIN = 2'd1, EVAL = 2'd2, SHOW = 2'd3} state_t;

  state_t           state_reg, state_next;
  logic [9:0]       money_reg, money_next;
  logic [3:0]       bet_reg, bet_next;
  logic [1:0]       reel_reg  [3];
  logic [1:0]       reel_next [3];
  logic             stop_reg, stop_next;
  logic             win_reg, win_next;
  logic             busy_reg, busy_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       lfsr_reg;
  logic             up_reg, down_reg, spin_reg;

  logic             up_edge, down_edge, spin_edge, spin_ok;
  logic [2:0]       reel_adv;
  logic             spin_done, show_done;
  logic             triple, pair;
  logic [10:0]      payout, money_sum;

  assign up_edge   = btn_up & ~up_reg;
  assign down_edge = btn_down & ~down_reg;
  assign spin_edge = btn_spin & ~spin_reg;
  // A spin needs enough credit for the current (pre-edge) bet; money=0 always fails.
  assign spin_ok   = spin_edge && (money_reg >= 10'(bet_reg));

  // Each reel keeps advancing until the shared counter reaches its own stop point.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_reel_stop
      localparam int STOP_PT = SPIN_FRAMES + gi * STAGGER;
      assign reel_adv[gi] = frame_tick && (cnt_reg < CNT_W'(STOP_PT));
    end
  endgenerate

  assign spin_done = frame_tick && (cnt_reg == CNT_W'(REEL3_STOP - 1));
  assign show_done = frame_tick && (cnt_reg == CNT_W'(WIN_FRAMES - 1));

  // Payout is formed in 11 bits so money + payout can exceed 999 before clamping.
  assign triple    = (reel_reg[0] == reel_reg[1]) && (reel_reg[1] == reel_reg[2]);
  assign pair      = (reel_reg[0] == reel_reg[1]) || (reel_reg[1] == reel_reg[2]);
  assign payout    = triple ? 11'({bet_reg, 3'b000}) :
                     pair   ? 11'({bet_reg, 1'b0})   : 11'd0;
  assign money_sum = 11'(money_reg) + payout;

  // State register and all datapath registers, including button history and LFSR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      money_reg <= 10'(MONEY_INIT);
      bet_reg   <= 4'd1;
      for (int i = 0; i < 3; i++) reel_reg[i] <= 2'd0;
      stop_reg  <= 1'b1;
      win_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
      lfsr_reg  <= LFSR_SEED;
      up_reg    <= 1'b0;
      down_reg  <= 1'b0;
      spin_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      money_reg <= money_next;
      bet_reg   <= bet_next;
      for (int i = 0; i < 3; i++) reel_reg[i] <= reel_next[i];
      stop_reg  <= stop_next;
      win_reg   <= win_next;
      busy_reg  <= busy_next;
      cnt_reg   <= cnt_next;
      lfsr_reg  <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
      up_reg    <= btn_up;
      down_reg  <= btn_down;
      spin_reg  <= btn_spin;
    end
  end

  // Next-state logic for the round sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (spin_ok) state_next = SPIN;
      SPIN:    if (spin_done) state_next = EVAL;
      EVAL:    state_next = (payout != 11'd0) ? SHOW : IDLE;
      SHOW:    if (show_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; buttons only act in IDLE, ticks only in SPIN/SHOW.
  always_comb begin
    money_next = money_reg;
    bet_next   = bet_reg;
    for (int i = 0; i < 3; i++) reel_next[i] = reel_reg[i];
    stop_next  = stop_reg;
    win_next   = win_reg;
    cnt_next   = cnt_reg;
    busy_next  = (state_next != IDLE);
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (spin_ok) begin
          money_next   = money_reg - 10'(bet_reg);
          stop_next    = 1'b0;
          reel_next[0] = lfsr_reg[1:0];
          reel_next[1] = lfsr_reg[3:2];
          reel_next[2] = lfsr_reg[5:4];
        end else if (up_edge && !down_edge && (bet_reg < 4'(BET_MAX))) begin
          bet_next = bet_reg + 4'd1;
        end else if (down_edge && !up_edge && (bet_reg > 4'd1)) begin
          bet_next = bet_reg - 4'd1;
        end
      end
      SPIN: begin
        if (frame_tick) begin
          for (int i = 0; i < 3; i++)
            if (reel_adv[i]) reel_next[i] = reel_reg[i] + 2'd1;
          cnt_next = cnt_reg + CNT_W'(1);
          if (spin_done) begin
            stop_next = 1'b1;
            cnt_next  = '0;
          end
        end
      end
      EVAL: begin
        money_next = (money_sum > 11'(MONEY_MAX)) ? MONEY_MAX : money_sum[9:0];
        win_next   = (payout != 11'd0);
        cnt_next   = '0;
      end
      SHOW: begin
        if (frame_tick) begin
          cnt_next = cnt_reg + CNT_W'(1);
          if (show_done) begin
            win_next = 1'b0;
            cnt_next = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign money = money_reg;
  assign bet   = bet_reg;
  assign reel1 = reel_reg[0];
  assign reel2 = reel_reg[1];
  assign reel3 = reel_reg[2];
  assign stop  = stop_reg;
  assign win   = win_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_slot_game_ctrl.sv
// Directed bench for slot_game_ctrl: reset, bet range, spin timing, payouts,
// abort by reset, and credit limits using two extra instances.
module tb_slot_game_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_spin = 1'b0;
  logic l_up = 1'b0, l_down = 1'b0, l_spin = 1'b0;

  logic [9:0] money, lo_money, hi_money;
  logic [3:0] bet, lo_bet, hi_bet;
  logic [1:0] reel1, reel2, reel3, lo_r1, lo_r2, lo_r3, hi_r1, hi_r2, hi_r3;
  logic       stop, win, busy, lo_stop, lo_win, lo_busy, hi_stop, hi_win, hi_busy;

  int n_cmp = 0;
  int n_mis = 0;
  int exp_money, exp_bet;
  logic [7:0] m_lfsr;

  slot_game_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_spin(btn_spin),
    .money(money), .bet(bet), .reel1(reel1), .reel2(reel2), .reel3(reel3),
    .stop(stop), .win(win), .busy(busy)
  );

  slot_game_ctrl #(.MONEY_INIT(5)) u_lo (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_up(l_up), .btn_down(l_down), .btn_spin(l_spin),
    .money(lo_money), .bet(lo_bet), .reel1(lo_r1), .reel2(lo_r2), .reel3(lo_r3),
    .stop(lo_stop), .win(lo_win), .busy(lo_busy)
  );

  slot_game_ctrl #(.MONEY_INIT(995)) u_hi (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_up(l_up), .btn_down(l_down), .btn_spin(l_spin),
    .money(hi_money), .bet(hi_bet), .reel1(hi_r1), .reel2(hi_r2), .reel3(hi_r3),
    .stop(hi_stop), .win(hi_win), .busy(hi_busy)
  );

  always #5 clk = ~clk;

  // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, reloaded with the seed on reset.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  function automatic int pay(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                             input int bt);
    if (a == b && b == c) return 8 * bt;
    if (a == b || b == c) return 2 * bt;
    return 0;
  endfunction

  // kind: 0 any, 1 triple, 2 pair only, 3 no match
  function automatic bit want(input logic [7:0] l, input int kind);
    logic [1:0] a, b, c;
    a = l[1:0]; b = l[3:2]; c = l[5:4];
    case (kind)
      1:       return (a == b) && (b == c);
      2:       return !((a == b) && (b == c)) && ((a == b) || (b == c));
      3:       return (a != b) && (b != c);
      default: return 1'b1;
    endcase
  endfunction

  task automatic spin_round(input int kind, input int abort_at);
    int waited;
    int p;
    int wcnt;
    logic [1:0] s1, s2, s3;
    waited = 0;
    while (!want(m_lfsr, kind) && waited < 600) begin
      cycle();
      waited++;
    end
    check("target_found", 32'(want(m_lfsr, kind)), 32'd1);
    if (!want(m_lfsr, kind)) return;
    s1 = m_lfsr[1:0]; s2 = m_lfsr[3:2]; s3 = m_lfsr[5:4];
    btn_spin = 1'b1;
    cycle();
    btn_spin = 1'b0;
    exp_money = exp_money - exp_bet;
    $display("spin kind=%0d bet=%0d reels=%0d/%0d/%0d money=%0d", kind, exp_bet, s1, s2, s3, money);
    check("spin_money", 32'(money), 32'(exp_money));
    check("spin_stop", 32'(stop), 32'd0);
    check("spin_busy", 32'(busy), 32'd1);
    check("spin_r1_load", 32'(reel1), 32'(s1));
    check("spin_r2_load", 32'(reel2), 32'(s2));
    check("spin_r3_load", 32'(reel3), 32'(s3));
    for (int t = 1; t <= 100; t++) begin
      do_tick();
      if (t == abort_at) begin
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        $display("abort at tick %0d money=%0d stop=%0d", t, money, stop);
        check("abort_money", 32'(money), 32'd100);
        check("abort_stop", 32'(stop), 32'd1);
        check("abort_reels", 32'({reel1, reel2, reel3}), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_win", 32'(win), 32'd0);
        check("abort_bet", 32'(bet), 32'd1);
        exp_money = 100;
        exp_bet = 1;
        return;
      end
      if (t == 59) check("r1_moving", 32'(reel1), 32'(2'(s1 + 2'd3)));
      if (t == 61) check("r1_frozen", 32'(reel1), 32'(s1));
      if (t == 79) check("r2_moving", 32'(reel2), 32'(2'(s2 + 2'd3)));
      if (t == 81) check("r2_frozen", 32'(reel2), 32'(s2));
      if (t == 99) begin
        check("r3_moving", 32'(reel3), 32'(2'(s3 + 2'd3)));
        check("stop_early", 32'(stop), 32'd0);
      end
      if (t == 100) begin
        check("stop_final", 32'(stop), 32'd1);
        check("r_final", 32'({reel1, reel2, reel3}), 32'({s1, s2, s3}));
      end
      if (t == 10 && abort_at > 0) begin
        btn_spin = 1'b1;
        btn_up = 1'b1;
        cycle();
        btn_spin = 1'b0;
        btn_up = 1'b0;
        check("spinbusy_bet", 32'(bet), 32'(exp_bet));
        check("spinbusy_money", 32'(money), 32'(exp_money));
        check("spinbusy_stop", 32'(stop), 32'd0);
      end else if (t != 100) begin
        cycle();
      end
    end
    cycle();
    p = pay(s1, s2, s3, exp_bet);
    exp_money = (exp_money + p > 999) ? 999 : exp_money + p;
    $display("eval payout=%0d money=%0d win=%0d", p, money, win);
    check("eval_money", 32'(money), 32'(exp_money));
    check("eval_win", 32'(win), 32'(p > 0));
    if (p > 0) begin
      wcnt = 0;
      while (win === 1'b1 && wcnt < 200) begin
        do_tick();
        wcnt++;
        cycle();
      end
      $display("show ticks=%0d", wcnt);
      check("win_ticks", 32'(wcnt), 32'd90);
      check("show_reels", 32'({reel1, reel2, reel3}), 32'({s1, s2, s3}));
    end
    check("round_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int waited;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("reset money=%0d bet=%0d stop=%0d", money, bet, stop);
    check("rst_money", 32'(money), 32'd100);
    check("rst_bet", 32'(bet), 32'd1);
    check("rst_reels", 32'({reel1, reel2, reel3}), 32'd0);
    check("rst_stop", 32'(stop), 32'd1);
    check("rst_win", 32'(win), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 12; i++) begin
      btn_up = 1'b1; cycle(); btn_up = 1'b0; cycle();
    end
    $display("12 up presses bet=%0d", bet);
    check("bet_max", 32'(bet), 32'd9);
    for (int i = 0; i < 12; i++) begin
      btn_down = 1'b1; cycle(); btn_down = 1'b0; cycle();
    end
    $display("12 down presses bet=%0d", bet);
    check("bet_min", 32'(bet), 32'd1);
    btn_up = 1'b1; cycle(); btn_up = 1'b0; cycle();
    check("bet_up1", 32'(bet), 32'd2);
    btn_up = 1'b1; btn_down = 1'b1; cycle(); btn_up = 1'b0; btn_down = 1'b0; cycle();
    $display("up+down together bet=%0d", bet);
    check("bet_both", 32'(bet), 32'd2);
    btn_up = 1'b1;
    repeat (50) cycle();
    btn_up = 1'b0;
    cycle();
    $display("up held 50 cycles bet=%0d", bet);
    check("bet_held", 32'(bet), 32'd3);
    for (int i = 0; i < 6; i++) begin
      btn_up = 1'b1; cycle(); btn_up = 1'b0; cycle();
    end
    check("bet_nine", 32'(bet), 32'd9);

    exp_money = 100;
    exp_bet = 9;
    spin_round(0, 0);
    spin_round(1, 0);
    spin_round(2, 0);
    spin_round(3, 0);
    spin_round(0, 30);

    // Credit limits: low-credit instance must refuse, high-credit one must clamp.
    for (int i = 0; i < 8; i++) begin
      l_up = 1'b1; cycle(); l_up = 1'b0; cycle();
    end
    check("lo_bet", 32'(lo_bet), 32'd9);
    check("hi_bet", 32'(hi_bet), 32'd9);
    waited = 0;
    while (!want(m_lfsr, 1) && waited < 600) begin
      cycle();
      waited++;
    end
    check("hi_target", 32'(want(m_lfsr, 1)), 32'd1);
    l_spin = 1'b1;
    cycle();
    l_spin = 1'b0;
    $display("limit spin lo money=%0d busy=%0d hi money=%0d busy=%0d", lo_money, lo_busy, hi_money, hi_busy);
    check("lo_money", 32'(lo_money), 32'd5);
    check("lo_busy", 32'(lo_busy), 32'd0);
    check("lo_stop", 32'(lo_stop), 32'd1);
    check("hi_spin_money", 32'(hi_money), 32'd986);
    check("hi_busy", 32'(hi_busy), 32'd1);
    for (int t = 1; t <= 100; t++) begin
      do_tick();
      if (t != 100) cycle();
    end
    cycle();
    $display("limit eval hi money=%0d win=%0d", hi_money, hi_win);
    check("hi_clamp", 32'(hi_money), 32'd999);
    check("hi_win", 32'(hi_win), 32'd1);
    check("lo_still_idle", 32'(lo_busy), 32'd0);
    check("idle_reels_hold", 32'({reel1, reel2, reel3}), 32'd0);
    check("idle_money_hold", 32'(money), 32'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
